// File: rtl/sd_data_rx_crc.sv
// SD single-line (DAT0) block receiver: start-bit detect, byte deserialiser,
// CRC-16 (x^16+x^12+x^5+1) check against the trailing CRC and end-bit check.
module sd_data_rx_crc #(
    parameter int BLKSIZE = 512,
    parameter int TIMEOUT = 1024
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic       ABORT,
    input  logic       DAT_IN,
    output logic [7:0] DATA_OUT,
    output logic       DATA_VALID,
    output logic       BUSY,
    output logic       DONE,
    output logic       CRC_OK,
    output logic       CRC_ERR,
    output logic       END_ERR,
    output logic       TIMEOUT_ERR
);

    localparam int BYTE_W = $clog2(BLKSIZE + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);

    localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BLKSIZE - 1);
    localparam logic [BYTE_W-1:0] BYTE_ONE  = BYTE_W'(1);
    localparam logic [TO_W-1:0]   LAST_WAIT = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]   TO_ONE    = TO_W'(1);
    localparam logic [15:0]       CRC_POLY  = 16'h1021;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_DATA,
        S_CRC,
        S_END
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic [3:0]        crc_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [6:0]        shift;
    logic [15:0]       crc;
    logic [15:0]       crc_rx;

    logic clear, wait_tick, timeout_hit, shift_data, shift_crc, finish;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        clear       = 1'b0;
        wait_tick   = 1'b0;
        timeout_hit = 1'b0;
        shift_data  = 1'b0;
        shift_crc   = 1'b0;
        finish      = 1'b0;
        if (ABORT) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        state_d = S_WAIT_START;
                        clear   = 1'b1;
                    end
                end
                S_WAIT_START: begin
                    if (!DAT_IN) begin
                        state_d = S_DATA;
                    end else if (to_cnt == LAST_WAIT) begin
                        timeout_hit = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        wait_tick = 1'b1;
                    end
                end
                S_DATA: begin
                    shift_data = 1'b1;
                    if (bit_cnt == 3'd7 && byte_cnt == LAST_BYTE) state_d = S_CRC;
                end
                S_CRC: begin
                    shift_crc = 1'b1;
                    if (crc_cnt == 4'hF) state_d = S_END;
                end
                S_END: begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    assign BUSY = (state_q != S_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            crc_cnt     <= '0;
            to_cnt      <= '0;
            shift       <= '0;
            crc         <= '0;
            crc_rx      <= '0;
            DATA_OUT    <= '0;
            DATA_VALID  <= 1'b0;
            DONE        <= 1'b0;
            CRC_OK      <= 1'b0;
            CRC_ERR     <= 1'b0;
            END_ERR     <= 1'b0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            DATA_VALID <= 1'b0;
            DONE       <= 1'b0;
            if (clear) begin
                bit_cnt     <= '0;
                byte_cnt    <= '0;
                crc_cnt     <= '0;
                to_cnt      <= '0;
                crc         <= '0;
                crc_rx      <= '0;
                CRC_OK      <= 1'b0;
                CRC_ERR     <= 1'b0;
                END_ERR     <= 1'b0;
                TIMEOUT_ERR <= 1'b0;
            end
            if (wait_tick) to_cnt <= to_cnt + TO_ONE;
            if (shift_data) begin
                shift   <= {shift[5:0], DAT_IN};
                crc     <= {crc[14:0], 1'b0} ^ ({16{DAT_IN ^ crc[15]}} & CRC_POLY);
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    DATA_OUT   <= {shift, DAT_IN};
                    DATA_VALID <= 1'b1;
                    byte_cnt   <= byte_cnt + BYTE_ONE;
                end
            end
            // The computed CRC stays frozen while the received one is captured.
            if (shift_crc) begin
                crc_rx  <= {crc_rx[14:0], DAT_IN};
                crc_cnt <= crc_cnt + 4'd1;
            end
            if (finish) begin
                DONE    <= 1'b1;
                CRC_OK  <= (crc_rx == crc);
                CRC_ERR <= (crc_rx != crc);
                END_ERR <= !DAT_IN;
            end
            if (timeout_hit) begin
                DONE        <= 1'b1;
                TIMEOUT_ERR <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sd_data_rx_crc.sv
// Directed bench for sd_data_rx_crc: expectations are scheduled per cycle from
// the block timing rules and a software CRC-16, then checked every cycle.
module tb_sd_data_rx_crc;

    localparam int BLK  = 512;
    localparam int TOUT = 1024;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       START = 1'b0;
    logic       ABORT = 1'b0;
    logic       DAT_IN = 1'b1;
    logic [7:0] DATA_OUT;
    logic       DATA_VALID, BUSY, DONE, CRC_OK, CRC_ERR, END_ERR, TIMEOUT_ERR;

    sd_data_rx_crc #(.BLKSIZE(BLK), .TIMEOUT(TOUT)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .DAT_IN(DAT_IN),
        .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .BUSY(BUSY), .DONE(DONE),
        .CRC_OK(CRC_OK), .CRC_ERR(CRC_ERR), .END_ERR(END_ERR), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int dv_count = 0;

    // Expected events keyed by cycle number.
    logic [7:0] dv_at   [int];
    bit         done_at [int];
    logic [3:0] stat_at [int];   // {CRC_OK, CRC_ERR, END_ERR, TIMEOUT_ERR}
    bit         busy_at [int];

    logic [7:0] blk [BLK];

    logic [7:0] exp_dout = 8'h00;
    logic [3:0] exp_stat = 4'h0;
    logic       exp_busy = 1'b0;
    logic       exp_dv   = 1'b0;
    logic       exp_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Byte-at-a-time software CRC-16/XMODEM over the current block.
    function automatic logic [15:0] block_crc();
        logic [15:0] c = 16'h0000;
        for (int i = 0; i < BLK; i++) begin
            c = c ^ {blk[i], 8'h00};
            for (int j = 0; j < 8; j++)
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    task automatic fill_const(input logic [7:0] v);
        for (int n = 0; n < BLK; n++) blk[n] = v;
    endtask

    task automatic fill_pattern(input int seed);
        for (int n = 0; n < BLK; n++) blk[n] = 8'(n * 37 + seed);
    endtask

    task automatic drive(input logic s, input logic a, input logic d);
        @(posedge CLK);
        #1;
        START  = s;
        ABORT  = a;
        DAT_IN = d;
    endtask

    // START, gap idle cycles, start bit, data, CRC, end bit; returns start-bit cycle.
    task automatic send_block(input logic [15:0] crc_tx, input logic end_bit,
                              input int gap, input int poke, output int s);
        logic [15:0] crc_exp;
        int t, d;
        crc_exp = block_crc();
        drive(1'b1, 1'b0, 1'b1);
        t = cyc;
        s = t + 1 + gap;
        d = s + 8 * BLK + 18;
        busy_at[t + 1] = 1'b1;
        stat_at[t + 1] = 4'b0000;
        for (int n = 0; n < BLK; n++) dv_at[s + 8 * n + 9] = blk[n];
        done_at[d] = 1'b1;
        busy_at[d] = 1'b0;
        stat_at[d] = {crc_tx == crc_exp, crc_tx != crc_exp, !end_bit, 1'b0};
        repeat (gap) drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8 * BLK; k++) drive(k == poke, 1'b0, blk[k / 8][7 - k % 8]);
        for (int k = 0; k < 16; k++) drive(1'b0, 1'b0, crc_tx[15 - k]);
        drive(1'b0, 1'b0, end_bit);
    endtask

    task automatic wait_done(input int ref_cyc, input int exp_lat, input int budget, input string name);
        int seen = -1;
        for (int i = 0; i < budget; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            if (DONE) begin
                seen = cyc - ref_cyc;
                break;
            end
        end
        check(name, seen, exp_lat);
    endtask

    // Per-cycle compare against the scheduled expectations.
    initial begin
        forever begin
            @(negedge CLK);
            if (RST) begin
                exp_dout = 8'h00; exp_stat = 4'h0; exp_busy = 1'b0;
                exp_dv = 1'b0; exp_done = 1'b0;
            end else begin
                exp_dv = dv_at.exists(cyc);
                if (exp_dv) exp_dout = dv_at[cyc];
                exp_done = done_at.exists(cyc);
                if (stat_at.exists(cyc)) exp_stat = stat_at[cyc];
                if (busy_at.exists(cyc)) exp_busy = busy_at[cyc];
            end
            if (DATA_VALID === 1'b1) dv_count++;
            check("DATA_VALID", DATA_VALID, exp_dv);
            check("DATA_OUT", DATA_OUT, exp_dout);
            check("DONE", DONE, exp_done);
            check("BUSY", BUSY, exp_busy);
            check("CRC_OK", CRC_OK, exp_stat[3]);
            check("CRC_ERR", CRC_ERR, exp_stat[2]);
            check("END_ERR", END_ERR, exp_stat[1]);
            check("TIMEOUT_ERR", TIMEOUT_ERR, exp_stat[0]);
        end
    end

    initial begin
        int s, t, a;

        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        check("reset_data_out", DATA_OUT, 8'h00);
        check("reset_busy", BUSY, 1'b0);
        check("reset_done", DONE, 1'b0);
        check("reset_status", {CRC_OK, CRC_ERR, END_ERR, TIMEOUT_ERR}, 4'h0);

        fill_const(8'h00);
        check("model_crc_zero", block_crc(), 16'h0000);
        fill_const(8'hFF);
        check("model_crc_ff", block_crc(), 16'h7FA1);

        // Good all-0xFF block, minimum START-to-start-bit spacing.
        dv_count = 0;
        send_block(16'h7FA1, 1'b1, 0, -1, s);
        wait_done(s, 4114, 8, "done_latency_ff");
        check("dv_count_ff", dv_count, 512);
        check("ff_crc_ok", CRC_OK, 1'b1);

        // Bad CRC, then an all-zero block started in the DONE cycle.
        send_block(16'h7FA0, 1'b1, 2, -1, s);
        fill_const(8'h00);
        send_block(16'h0000, 1'b1, 0, -1, s);
        repeat (3) drive(1'b0, 1'b0, 1'b1);
        check("zero_crc_ok", CRC_OK, 1'b1);
        check("zero_crc_err", CRC_ERR, 1'b0);

        // Good CRC but end bit 0.
        fill_const(8'hFF);
        send_block(16'h7FA1, 1'b0, 3, -1, s);
        wait_done(s, 4114, 8, "done_latency_endbit");
        check("endbit_end_err", END_ERR, 1'b1);
        check("endbit_crc_ok", CRC_OK, 1'b1);

        // Varied data with a stray START pulse mid-block.
        fill_pattern(11);
        send_block(block_crc(), 1'b1, 1, 1000, s);
        wait_done(s, 4114, 8, "done_latency_poke");

        // START and ABORT together in IDLE: stays idle.
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        check("start_abort_idle", BUSY, 1'b0);

        // ABORT in the middle of byte 100.
        fill_pattern(3);
        drive(1'b1, 1'b0, 1'b1);
        t = cyc;
        s = t + 2;
        busy_at[t + 1] = 1'b1;
        stat_at[t + 1] = 4'b0000;
        for (int n = 0; n < 100; n++) dv_at[s + 8 * n + 9] = blk[n];
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8 * 100 + 4; k++) drive(1'b0, 1'b0, blk[k / 8][7 - k % 8]);
        drive(1'b0, 1'b1, blk[100][3]);
        a = cyc;
        busy_at[a + 1] = 1'b0;
        drive(1'b0, 1'b0, 1'b1);
        check("abort_busy", BUSY, 1'b0);
        repeat (20) drive(1'b0, 1'b0, 1'b1);

        fill_const(8'hFF);
        send_block(16'h7FA1, 1'b1, 0, -1, s);
        wait_done(s, 4114, 8, "done_latency_after_abort");
        check("after_abort_crc_ok", CRC_OK, 1'b1);

        // No start bit: timeout.
        dv_count = 0;
        drive(1'b1, 1'b0, 1'b1);
        t = cyc;
        busy_at[t + 1] = 1'b1;
        stat_at[t + 1] = 4'b0000;
        done_at[t + TOUT + 1] = 1'b1;
        busy_at[t + TOUT + 1] = 1'b0;
        stat_at[t + TOUT + 1] = 4'b0001;
        wait_done(t, 1025, TOUT + 8, "timeout_latency");
        check("timeout_err", TIMEOUT_ERR, 1'b1);
        check("timeout_no_dv", dv_count, 0);

        // Reset in the middle of DATA.
        fill_pattern(5);
        drive(1'b1, 1'b0, 1'b1);
        t = cyc;
        s = t + 1;
        busy_at[t + 1] = 1'b1;
        stat_at[t + 1] = 4'b0000;
        for (int n = 0; n < BLK; n++) dv_at[s + 8 * n + 9] = blk[n];
        drive(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8 * 50 + 3; k++) drive(1'b0, 1'b0, blk[k / 8][7 - k % 8]);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        dv_at.delete();
        done_at.delete();
        stat_at.delete();
        busy_at.delete();
        #1;
        check("rst_data_out", DATA_OUT, 8'h00);
        check("rst_busy", BUSY, 1'b0);
        check("rst_status", {CRC_OK, CRC_ERR, END_ERR, TIMEOUT_ERR}, 4'h0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1);
        RST = 1'b0;
        drive(1'b0, 1'b0, 1'b1);

        fill_pattern(200);
        send_block(block_crc(), 1'b1, 0, -1, s);
        wait_done(s, 4114, 8, "done_latency_after_rst");
        check("after_rst_crc_ok", CRC_OK, 1'b1);
        repeat (4) drive(1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
